// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache responder for the pre-IF fetch port.
// Hits answer the cycle after acceptance; misses refill one line over a burst port, then replay.
module icache_responder #(
  parameter int INDEX_W  = 8,
  parameter int TAG_W    = 20,
  parameter int OFFSET_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic                op,
  input  logic [INDEX_W-1:0]  index,
  input  logic [TAG_W-1:0]    tag,
  input  logic [OFFSET_W-1:0] offset,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  output logic                rd_req,
  output logic [2:0]          rd_type,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data
);

  localparam int LINES      = 2 ** INDEX_W;
  localparam int WORD_W     = OFFSET_W - 2;
  localparam int LINE_WORDS = 2 ** WORD_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0]   off_q, off_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_arr_q  [LINES];
  logic [31:0]         data_arr_q [LINES][LINE_WORDS];

  logic hit;
  logic accept;
  logic beat_we;
  logic line_fill;
  logic unused_inputs;

  // op=1 is serviced as a read and byte lanes within a word are never selected
  assign unused_inputs = ^{op, offset[1:0]};

  always_comb begin
    hit       = (state_q == LOOKUP) && valid_q[idx_q] && (tag_arr_q[idx_q] == tag_q);
    accept    = valid && !reset && ((state_q == IDLE) || hit);
    beat_we   = (state_q == REFILL) && ret_valid && !reset;
    line_fill = beat_we && ret_last;

    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    off_d   = off_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE:   if (accept) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) state_d = accept ? LOOKUP : IDLE;
        else     state_d = MISS;
      end
      MISS: begin
        if (rd_rdy) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        if (ret_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (ret_last) state_d = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      tag_d = tag;
      idx_d = index;
      off_d = offset[OFFSET_W-1:2];
    end

    addr_ok = accept;
    data_ok = hit;
    rdata   = hit ? data_arr_q[idx_q][off_q] : '0;
    rd_req  = (state_q == MISS);
    rd_type = 3'b100;
    rd_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      if (line_fill) valid_q[idx_q] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; a line is only trusted once its valid bit is set
  always_ff @(posedge clk) begin
    if (beat_we)   data_arr_q[idx_q][cnt_q] <= ret_data;
    if (line_fill) tag_arr_q[idx_q]         <= tag_q;
  end

endmodule

// File: tb/tb_icache_responder.sv
// Cycle-by-cycle directed vectors for icache_responder: each row drives inputs for one
// cycle and holds the expected outputs for that same cycle.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        op;
  logic [7:0]  index;
  logic [19:0] tag;
  logic [3:0]  offset;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int checks   = 0;
  int failures = 0;
  int row      = 0;
  logic op_drv = 1'b0;

  localparam logic [31:0] A1 = 32'h12345100;
  localparam logic [31:0] A2 = 32'h54321100;
  localparam logic [31:0] A4 = 32'h0ABCD200;
  localparam logic [31:0] A5 = 32'h11111300;

  always #5 clk = ~clk;

  icache_responder #(.INDEX_W(8), .TAG_W(20), .OFFSET_W(4)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .index(index), .tag(tag),
    .offset(offset), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [19:0] tg;
    logic [7:0]  ix;
    logic [3:0]  of;
    logic        rdy;
    logic        rv;
    logic        rl;
    logic [31:0] rd;
    logic        aok;
    logic        dok;
    logic [31:0] rdat;
    logic        rreq;
    logic [31:0] raddr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic v, input logic [19:0] tg,
                              input logic [7:0] ix, input logic [3:0] of, input logic rdy,
                              input logic rv, input logic rl, input logic [31:0] rd,
                              input logic aok, input logic dok, input logic [31:0] rdat,
                              input logic rreq, input logic [31:0] raddr);
    vec_t t;
    t.rst = rst; t.v = v; t.tg = tg; t.ix = ix; t.of = of;
    t.rdy = rdy; t.rv = rv; t.rl = rl; t.rd = rd;
    t.aok = aok; t.dok = dok; t.rdat = rdat; t.rreq = rreq; t.raddr = raddr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    reset     = t.rst;
    valid     = t.v;
    op        = op_drv;
    tag       = t.tg;
    index     = t.ix;
    offset    = t.of;
    rd_rdy    = t.rdy;
    ret_valid = t.rv;
    ret_last  = t.rl;
    ret_data  = t.rd;
    #1;
    chk("addr_ok", {31'b0, addr_ok}, {31'b0, t.aok});
    chk("data_ok", {31'b0, data_ok}, {31'b0, t.dok});
    chk("rdata",   rdata, t.rdat);
    chk("rd_req",  {31'b0, rd_req}, {31'b0, t.rreq});
    chk("rd_addr", rd_addr, t.raddr);
    chk("rd_type", {29'b0, rd_type}, 32'h4);
    row++;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    reset = 1'b1; valid = 1'b0; op = 1'b0; tag = '0; index = '0; offset = '0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
    repeat (2) @(posedge clk);

    // Miss/refill, back-to-back hits, conflicting tag on the same index
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,0,0,0,A1 & 32'h0));
    tbl.push_back(mk(0,1,'h12345,'h10,'h4, 0,0,0,0,        1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,0,0,1,A1));
    tbl.push_back(mk(0,0,0,0,0,        1,0,0,0,            0,0,0,1,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hA0,         0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hA1,         0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hA2,         0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,1,'hA3,         0,0,0,0,A1));
    tbl.push_back(mk(0,1,'h12345,'h10,'h0, 0,0,0,0,        1,1,'hA1,0,A1));
    tbl.push_back(mk(0,1,'h12345,'h10,'h8, 0,0,0,0,        1,1,'hA0,0,A1));
    tbl.push_back(mk(0,1,'h12345,'h10,'hC, 0,0,0,0,        1,1,'hA2,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,1,'hA3,0,A1));
    tbl.push_back(mk(0,1,'h54321,'h10,'h0, 0,0,0,0,        1,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,0,0,0,A2));
    tbl.push_back(mk(0,0,0,0,0,        1,0,0,0,            0,0,0,1,A2));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hB0,         0,0,0,0,A2));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,0,0,0,A2));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hB1,         0,0,0,0,A2));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hB2,         0,0,0,0,A2));
    tbl.push_back(mk(0,0,0,0,0,        0,1,1,'hB3,         0,0,0,0,A2));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,1,'hB0,0,A2));
    tbl.push_back(mk(0,1,'h12345,'h10,'h4, 0,0,0,0,        1,0,0,0,A2));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,1,'hDEADBEEF,   0,0,0,1,A1));
    tbl.push_back(mk(0,0,0,0,0,        1,0,0,0,            0,0,0,1,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hC0,         0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hC1,         0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,0,'hC2,         0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,1,1,'hC3,         0,0,0,0,A1));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,            0,1,'hC1,0,A1));
    foreach (tbl[i]) apply(tbl[i]);

    // Stalled bridge: rd_req held, address stable, new requests refused (op=1 from here on)
    op_drv = 1'b1;
    apply(mk(0,1,'h0ABCD,'h20,'h8, 0,0,0,0, 1,0,0,0,A1));
    apply(mk(0,0,0,0,0,            0,0,0,0, 0,0,0,0,A4));
    for (int unsigned k = 0; k < 5; k++)
      apply(mk(0,1,'h12345,'h10,'h4, 0,0,0,0, 0,0,0,1,A4));
    apply(mk(0,0,0,0,0, 1,0,0,0,     0,0,0,1,A4));
    for (int unsigned k = 0; k < 4; k++)
      apply(mk(0,0,0,0,0, 0,1,(k == 3),32'hD0 + k, 0,0,0,0,A4));
    apply(mk(0,0,0,0,0, 0,0,0,0,     0,1,'hD2,0,A4));

    // Stray refill beats while IDLE leave both resident lines intact
    for (int unsigned k = 0; k < 3; k++)
      apply(mk(0,0,0,0,0, 0,1,k[0],32'hFFFF_FFF0 + k, 0,0,0,0,A4));
    apply(mk(0,1,'h12345,'h10,'h4, 0,0,0,0, 1,0,0,0,A4));
    apply(mk(0,1,'h0ABCD,'h20,'h8, 0,0,0,0, 1,1,'hC1,0,A1));
    apply(mk(0,0,0,0,0,            0,0,0,0, 0,1,'hD2,0,A4));

    // Reset mid-refill: partial line dropped, late beats ignored, same address misses
    seq.push_back(mk(0,1,'h11111,'h30,'h0, 0,0,0,0, 1,0,0,0,A4));
    seq.push_back(mk(0,0,0,0,0,  0,0,0,0,         0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  1,0,0,0,         0,0,0,1,A5));
    seq.push_back(mk(0,0,0,0,0,  0,1,0,'hE0,      0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  0,1,0,'hE1,      0,0,0,0,A5));
    seq.push_back(mk(1,1,'h11111,'h30,'h0, 0,1,0,'hE2, 0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  0,1,1,'hE3,      0,0,0,0,0));
    seq.push_back(mk(0,1,'h11111,'h30,'h0, 0,0,0,0, 1,0,0,0,0));
    seq.push_back(mk(0,0,0,0,0,  0,0,0,0,         0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  1,0,0,0,         0,0,0,1,A5));
    seq.push_back(mk(0,0,0,0,0,  0,1,0,'hF0,      0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  0,1,0,'hF1,      0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  0,1,0,'hF2,      0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  0,1,1,'hF3,      0,0,0,0,A5));
    seq.push_back(mk(0,0,0,0,0,  0,0,0,0,         0,1,'hF0,0,A5));
    // Reset in IDLE with a request pending: addr_ok forced low, every line invalidated
    seq.push_back(mk(1,1,'h12345,'h10,'h4, 0,0,0,0, 0,0,0,0,A5));
    seq.push_back(mk(0,1,'h12345,'h10,'h4, 0,0,0,0, 1,0,0,0,0));
    seq.push_back(mk(0,0,0,0,0,  0,0,0,0,         0,0,0,0,A1));
    seq.push_back(mk(0,0,0,0,0,  0,0,0,0,         0,0,0,1,A1));
    foreach (seq[i]) apply(seq[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
